// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the byte-stream instruction decoder:
//   the 3-bit opcode encodings and the decoder FSM state encoding.
package cpu_pkg;

    // Opcode lives in the top three bits of the instruction byte.
    localparam int OPCODE_W = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_LDI = 3'b110,  // two-byte: opcode byte followed by immediate byte
        OP_ILL = 3'b111
    } opcode_t;

    typedef enum logic {
        S_OP  = 1'b0,     // expecting an opcode byte
        S_IMM = 1'b1      // expecting the immediate byte of an LDI
    } state_t;

endpackage

// File: rtl/field_split.sv
// field_split
//   Combinational slicer: splits an instruction byte into opcode, rd and rs
//   fields, zero-extending rd and rs to the register address width.
//   Layout (MSB..LSB): opcode[2:0] | rd[RD_FW-1:0] | rs[remaining bits]
// Ports:
//   inst_i    in   DATA_W   instruction byte
//   opcode_o  out  3        opcode field
//   rd_o      out  REG_AW   rd field, zero-extended
//   rs_o      out  REG_AW   rs field, zero-extended
module field_split
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_FW  = 2,
    parameter int REG_AW = 3
) (
    input  logic [DATA_W-1:0]   inst_i,
    output logic [OPCODE_W-1:0] opcode_o,
    output logic [REG_AW-1:0]   rd_o,
    output logic [REG_AW-1:0]   rs_o
);

    localparam int RS_W = DATA_W - OPCODE_W - RD_FW;

    assign opcode_o = inst_i[DATA_W-1 -: OPCODE_W];

    // Assign-then-overlay keeps zero extension legal when REG_AW equals the
    // field width (a zero-count replication would not be).
    always_comb begin
        rd_o = '0;
        rs_o = '0;
        rd_o[RD_FW-1:0] = inst_i[DATA_W-OPCODE_W-1 -: RD_FW];
        rs_o[RS_W-1:0]  = inst_i[RS_W-1:0];
    end

endmodule

// File: rtl/seq_decoder.sv
// seq_decoder
//   Decodes a stream of instruction bytes into micro-ops. Single-byte ops
//   (ADD..NOT and the illegal opcode) produce a micro-op one cycle after
//   transfer; LDI takes a second byte as its immediate. A one-entry output
//   register decouples the consumer; illegal opcodes bump a saturating counter.
//
//   Handshake: a byte moves when in_valid && in_ready at a rising clk edge;
//   a micro-op moves when out_valid && out_ready at a rising clk edge.
//   in_ready is combinational from out_ready (space exists when the output
//   register is empty or draining this cycle) and is low during flush/rst.
// Ports:
//   clk, rst             clock (rising), async active-high reset
//   flush                sync abort of partial LDI and pending micro-op
//   in_valid/in_ready    byte input handshake, in_inst = byte
//   out_valid/out_ready  micro-op output handshake
//   out_opcode/rd/rs     decoded fields; out_imm = immediate (0 if !out_is_imm)
//   out_is_imm           micro-op carries an immediate (LDI)
//   out_illegal          micro-op came from opcode 111
//   busy                 FSM state bit: high while in S_IMM
//   illegal_cnt          saturating count of illegal opcodes
module seq_decoder
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_FW  = 2,
    parameter int REG_AW = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_opcode,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_is_imm,
    output logic              out_illegal,
    output logic              busy,
    output logic [CNT_W-1:0]  illegal_cnt
);

    logic [OPCODE_W-1:0] fs_opcode;
    logic [REG_AW-1:0]   fs_rd;
    logic [REG_AW-1:0]   fs_rs;

    field_split #(
        .DATA_W (DATA_W),
        .RD_FW  (RD_FW),
        .REG_AW (REG_AW)
    ) u_field_split (
        .inst_i   (in_inst),
        .opcode_o (fs_opcode),
        .rd_o     (fs_rd),
        .rs_o     (fs_rs)
    );

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [OPCODE_W-1:0] out_opcode_q, out_opcode_d;
    logic [REG_AW-1:0]   out_rd_q, out_rd_d;
    logic [REG_AW-1:0]   out_rs_q, out_rs_d;
    logic [DATA_W-1:0]   out_imm_q, out_imm_d;
    logic                out_is_imm_q, out_is_imm_d;
    logic                out_illegal_q, out_illegal_d;
    logic [OPCODE_W-1:0] lat_opcode_q, lat_opcode_d;
    logic [REG_AW-1:0]   lat_rd_q, lat_rd_d;
    logic [REG_AW-1:0]   lat_rs_q, lat_rs_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                xfer;

    assign in_ready = !rst && !flush && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q && !out_ready;  // drains unless reloaded
        out_opcode_d  = out_opcode_q;
        out_rd_d      = out_rd_q;
        out_rs_d      = out_rs_q;
        out_imm_d     = out_imm_q;
        out_is_imm_d  = out_is_imm_q;
        out_illegal_d = out_illegal_q;
        lat_opcode_d  = lat_opcode_q;
        lat_rd_d      = lat_rd_q;
        lat_rs_d      = lat_rs_q;
        cnt_d         = cnt_q;

        if (flush) begin
            // in_ready is already low, so no byte can be taken here.
            state_d     = S_OP;
            out_valid_d = 1'b0;
        end else if (xfer) begin
            unique case (state_q)
                S_OP: begin
                    if (fs_opcode == OP_LDI) begin
                        lat_opcode_d = fs_opcode;
                        lat_rd_d     = fs_rd;
                        lat_rs_d     = fs_rs;
                        state_d      = S_IMM;
                    end else begin
                        out_valid_d   = 1'b1;
                        out_opcode_d  = fs_opcode;
                        out_rd_d      = fs_rd;
                        out_rs_d      = fs_rs;
                        out_imm_d     = '0;
                        out_is_imm_d  = 1'b0;
                        out_illegal_d = (fs_opcode == OP_ILL);
                        if (fs_opcode == OP_ILL && cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_IMM: begin
                    out_valid_d   = 1'b1;
                    out_opcode_d  = lat_opcode_q;
                    out_rd_d      = lat_rd_q;
                    out_rs_d      = lat_rs_q;
                    out_imm_d     = in_inst;
                    out_is_imm_d  = 1'b1;
                    out_illegal_d = 1'b0;
                    state_d       = S_OP;
                end
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_OP;
            out_valid_q   <= 1'b0;
            out_opcode_q  <= '0;
            out_rd_q      <= '0;
            out_rs_q      <= '0;
            out_imm_q     <= '0;
            out_is_imm_q  <= 1'b0;
            out_illegal_q <= 1'b0;
            lat_opcode_q  <= '0;
            lat_rd_q      <= '0;
            lat_rs_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_rd_q      <= out_rd_d;
            out_rs_q      <= out_rs_d;
            out_imm_q     <= out_imm_d;
            out_is_imm_q  <= out_is_imm_d;
            out_illegal_q <= out_illegal_d;
            lat_opcode_q  <= lat_opcode_d;
            lat_rd_q      <= lat_rd_d;
            lat_rs_q      <= lat_rs_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opcode  = out_opcode_q;
    assign out_rd      = out_rd_q;
    assign out_rs      = out_rs_q;
    assign out_imm     = out_imm_q;
    assign out_is_imm  = out_is_imm_q;
    assign out_illegal = out_illegal_q;
    assign busy        = (state_q == S_IMM);
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder
//   Directed bench for seq_decoder. The stimulus process pushes the expected
//   micro-op into exp_q whenever it issues the byte that completes one; a
//   monitor pops and compares on every output handshake.
module tb_seq_decoder;

    localparam int DATA_W = 8;
    localparam int RD_FW  = 2;
    localparam int REG_AW = 3;
    localparam int CNT_W  = 8;
    localparam int UOP_W  = 3 + 2*REG_AW + DATA_W + 2;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_opcode;
    logic [REG_AW-1:0] out_rd;
    logic [REG_AW-1:0] out_rs;
    logic [DATA_W-1:0] out_imm;
    logic              out_is_imm;
    logic              out_illegal;
    logic              busy;
    logic [CNT_W-1:0]  illegal_cnt;

    seq_decoder #(
        .DATA_W (DATA_W),
        .RD_FW  (RD_FW),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs      (out_rs),
        .out_imm     (out_imm),
        .out_is_imm  (out_is_imm),
        .out_illegal (out_illegal),
        .busy        (busy),
        .illegal_cnt (illegal_cnt)
    );

    // ---------------- clock / reset ----------------
    int cyc;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [UOP_W-1:0] exp_q[$];
    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [UOP_W-1:0] mk(input logic [2:0] op, input logic [REG_AW-1:0] rd,
                                            input logic [REG_AW-1:0] rs, input logic [DATA_W-1:0] imm,
                                            input logic is_imm, input logic ill);
        return {op, rd, rs, imm, is_imm, ill};
    endfunction

    // Monitor: a micro-op is consumed at each rising edge that sees
    // out_valid && out_ready; sample both on the falling edge before it.
    initial begin
        logic [UOP_W-1:0] act;
        logic [UOP_W-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                act = {out_opcode, out_rd, out_rs, out_imm, out_is_imm, out_illegal};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL uop_unexpected: got 0x%0h expected no output", act);
                end else begin
                    exp = exp_q.pop_front();
                    chk("uop", 32'(act), 32'(exp));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Entered just after a rising edge; returns just after the edge that
    // transferred the byte.
    task automatic send(input logic [DATA_W-1:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_inst  = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for byte 0x%0h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(illegal_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_fields", 32'({out_opcode, out_rd, out_rs, out_imm, out_is_imm, out_illegal}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD rd=1 rs=3, then latency of one cycle
        exp_q.push_back(mk(3'd0, 3'd1, 3'd3, 8'h00, 1'b0, 1'b0));
        send(8'h0B);
        chk("add_latency_valid", 32'(out_valid), 1);
        idle(2);

        // Back-to-back single-byte ops: one byte per cycle
        exp_q.push_back(mk(3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 1'b0));  // 0x29 SUB
        exp_q.push_back(mk(3'd2, 3'd3, 3'd6, 8'h00, 1'b0, 1'b0));  // 0x5E AND
        exp_q.push_back(mk(3'd3, 3'd0, 3'd4, 8'h00, 1'b0, 1'b0));  // 0x64 OR
        exp_q.push_back(mk(3'd4, 3'd3, 3'd7, 8'h00, 1'b0, 1'b0));  // 0x9F XOR
        exp_q.push_back(mk(3'd5, 3'd1, 3'd0, 8'h00, 1'b0, 1'b0));  // 0xA8 NOT
        t0 = cyc;
        send(8'h29);
        send(8'h5E);
        send(8'h64);
        send(8'h9F);
        send(8'hA8);
        chk("throughput_cycles", 32'(cyc - t0), 5);

        // LDI 0xD2 / 0x5A, with idle cycles while waiting for the immediate
        send(8'hD2);
        chk("ldi_busy", 32'(busy), 1);
        chk("ldi_no_output", 32'(out_valid), 0);
        idle(3);
        chk("ldi_busy_hold", 32'(busy), 1);
        exp_q.push_back(mk(3'd6, 3'd2, 3'd2, 8'h5A, 1'b1, 1'b0));
        send(8'h5A);
        chk("ldi_busy_clear", 32'(busy), 0);
        chk("ldi_valid", 32'(out_valid), 1);
        idle(2);

        // Backpressure: 5 stalled cycles, next byte waits and is not lost
        out_ready = 1'b0;
        exp_q.push_back(mk(3'd0, 3'd1, 3'd3, 8'h00, 1'b0, 1'b0));
        send(8'h0B);
        in_valid = 1'b1;
        in_inst  = 8'h29;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_hold", 32'({out_valid, out_opcode, out_rd, out_rs, out_imm, out_is_imm}),
                32'({1'b1, 3'd0, 3'd1, 3'd3, 8'h00, 1'b0}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back(mk(3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 1'b0));
        send(8'h29);
        idle(2);

        // Illegal opcode stream, counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(mk(3'd7, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1));
            send(8'hE0);
            if (i == 253) chk("cnt_254", 32'(illegal_cnt), 254);
            if (i == 254) chk("cnt_255", 32'(illegal_cnt), 255);
        end
        chk("cnt_saturated", 32'(illegal_cnt), 255);
        idle(2);

        // Flush mid-LDI with a byte offered: dropped, back to S_OP
        send(8'hD2);
        chk("flush_pre_busy", 32'(busy), 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 8'hE0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", 32'(busy), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_cnt", 32'(illegal_cnt), 255);
        exp_q.push_back(mk(3'd1, 3'd1, 3'd1, 8'h00, 1'b0, 1'b0));
        send(8'h29);
        idle(2);

        // Async reset between edges while in S_IMM
        send(8'hD2);
        chk("arst_pre_busy", 32'(busy), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cnt", 32'(illegal_cnt), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Partial LDI was discarded: 0x5A now decodes as AND rd=3 rs=2
        exp_q.push_back(mk(3'd2, 3'd3, 3'd2, 8'h00, 1'b0, 1'b0));
        send(8'h5A);
        idle(3);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
